// File: rtl/als_pkg.sv
// als_pkg: shared types and constants for the ALS white-balance gain block.
//   gain_t      default-width gain word (12 bits, 4.8 unsigned fixed point)
//   wb_state_t  gain FSM states
//   GAIN_ONE    unity gain at the default fractional width
package als_pkg;
    localparam int GAIN_BITS_DEF = 12;
    localparam int GAIN_FRAC_DEF = 8;
    localparam int GAIN_ONE      = 1 << GAIN_FRAC_DEF;

    typedef logic [GAIN_BITS_DEF-1:0] gain_t;

    typedef enum logic [2:0] {IDLE, DIV_R, DIV_B, FILTER, PRESENT} wb_state_t;
endpackage

// File: rtl/als_wb_gain_if.sv
// als_wb_gain_if: gain-pair valid/ready handshake.
//   r_gain, b_gain  gain pair, stable while gain_valid is high
//   gain_valid      gain pair available (driven by master)
//   gain_ready      consumer accepts the pair (driven by slave)
interface als_wb_gain_if #(
    parameter int GAIN_BITS = 12
);
    logic [GAIN_BITS-1:0] r_gain;
    logic [GAIN_BITS-1:0] b_gain;
    logic                 gain_valid;
    logic                 gain_ready;

    modport master (output r_gain, b_gain, gain_valid, input gain_ready);
    modport slave  (input r_gain, b_gain, gain_valid, output gain_ready);
endinterface

// File: rtl/seq_udiv.sv
// seq_udiv: unsigned restoring divider, one quotient bit per clock.
//   start     pulse; dividend/divisor are sampled and the first bit is produced on this edge
//   dividend  N_BITS numerator
//   divisor   D_BITS denominator; zero yields an all-ones quotient
//   quotient  valid while done is high
//   done      one-cycle pulse, N_BITS cycles after start
module seq_udiv #(
    parameter int N_BITS = 18,
    parameter int D_BITS = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [N_BITS-1:0] dividend,
    input  logic [D_BITS-1:0] divisor,
    output logic [N_BITS-1:0] quotient,
    output logic              done
);
    localparam int CNT_W = $clog2(N_BITS + 1);

    logic [D_BITS-1:0] rem, div, src_rem, src_div, new_rem;
    logic [N_BITS-1:0] src_q;
    logic [D_BITS:0]   sh;
    logic              ge, running;
    logic [CNT_W-1:0]  cnt;

    // The quotient register doubles as the dividend shifter: numerator bits
    // leave at the top while quotient bits enter at the bottom.
    assign src_rem = start ? '0 : rem;
    assign src_q   = start ? dividend : quotient;
    assign src_div = start ? divisor : div;
    assign sh      = {src_rem, src_q[N_BITS-1]};
    // A zero divisor makes every compare succeed, so the quotient saturates to all ones.
    assign ge      = sh >= {1'b0, src_div};
    assign new_rem = ge ? D_BITS'(sh - {1'b0, src_div}) : sh[D_BITS-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem      <= '0;
            div      <= '0;
            quotient <= '0;
            cnt      <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start || running) begin
                rem      <= new_rem;
                quotient <= {src_q[N_BITS-2:0], ge};
            end
            if (start) begin
                div     <= divisor;
                cnt     <= CNT_W'(N_BITS - 1);
                running <= 1'b1;
            end else if (running) begin
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/als_wb_gain.sv
// als_wb_gain: red/blue white-balance gains from per-channel Bayer averages.
//   clk, reset_n      core clock, asynchronous active-low reset
//   enable            when low, new statistics are ignored
//   avg_valid         one-cycle pulse qualifying ch0..ch3 (Gr, R, B, Gb)
//   busy              high whenever the FSM is not idle
//   drop_count        saturating count of statistics discarded while busy
//   gain              master side of the gain-pair valid/ready handshake
module als_wb_gain
    import als_pkg::*;
#(
    parameter int AVG_BITS  = 10,
    parameter int GAIN_BITS = 12,
    parameter int GAIN_FRAC = 8,
    parameter int GAIN_MIN  = 32,
    parameter int GAIN_MAX  = 1024,
    parameter int IIR_SHIFT = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                avg_valid,
    input  logic [AVG_BITS-1:0] ch0_avg,
    input  logic [AVG_BITS-1:0] ch1_avg,
    input  logic [AVG_BITS-1:0] ch2_avg,
    input  logic [AVG_BITS-1:0] ch3_avg,
    output logic                busy,
    output logic [15:0]         drop_count,
    als_wb_gain_if.master       gain
);
    localparam int Q_BITS = AVG_BITS + GAIN_FRAC;
    localparam logic [GAIN_BITS-1:0] ONE = GAIN_BITS'(1 << GAIN_FRAC);

    wb_state_t            state;
    logic                 first_done, kick;
    logic [AVG_BITS-1:0]  g_ref, r_avg, b_avg, g_sat, divisor;
    logic [AVG_BITS:0]    g_sum;
    logic [GAIN_BITS-1:0] r_clamp, b_clamp, q_clamp;
    logic [Q_BITS-1:0]    quo;
    logic                 div_start, div_done;

    function automatic logic [GAIN_BITS-1:0] smooth(input logic [GAIN_BITS-1:0] cur,
                                                     input logic [GAIN_BITS-1:0] tgt);
        logic signed [GAIN_BITS:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        diff = diff >>> IIR_SHIFT;
        return cur + diff[GAIN_BITS-1:0];
    endfunction

    assign g_sum = ({1'b0, ch0_avg} + {1'b0, ch3_avg} + (AVG_BITS+1)'(1)) >> 1;
    assign g_sat = g_sum[AVG_BITS] ? '1 : g_sum[AVG_BITS-1:0];
    assign busy  = (state != IDLE);

    // The R divide is kicked one cycle after latching; the B divide starts on
    // the very cycle the R result appears, so the divider never idles between them.
    assign div_start = kick || (state == DIV_R && div_done);
    assign divisor   = (state == DIV_R && !div_done) ? r_avg : b_avg;
    assign q_clamp   = quo < Q_BITS'(GAIN_MIN) ? GAIN_BITS'(GAIN_MIN) :
                       quo > Q_BITS'(GAIN_MAX) ? GAIN_BITS'(GAIN_MAX) : quo[GAIN_BITS-1:0];

    seq_udiv #(.N_BITS(Q_BITS), .D_BITS(AVG_BITS)) u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (div_start),
        .dividend ({g_ref, GAIN_FRAC'(0)}),
        .divisor  (divisor),
        .quotient (quo),
        .done     (div_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            first_done      <= 1'b0;
            kick            <= 1'b0;
            g_ref           <= '0;
            r_avg           <= '0;
            b_avg           <= '0;
            r_clamp         <= ONE;
            b_clamp         <= ONE;
            drop_count      <= '0;
            gain.r_gain     <= ONE;
            gain.b_gain     <= ONE;
            gain.gain_valid <= 1'b0;
        end else begin
            kick <= 1'b0;
            if (avg_valid && enable && state != IDLE && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
            case (state)
                IDLE: if (avg_valid && enable) begin
                    g_ref <= g_sat;
                    r_avg <= ch1_avg;
                    b_avg <= ch2_avg;
                    kick  <= 1'b1;
                    state <= DIV_R;
                end
                DIV_R: if (div_done) begin
                    r_clamp <= q_clamp;
                    state   <= DIV_B;
                end
                DIV_B: if (div_done) begin
                    b_clamp <= q_clamp;
                    state   <= FILTER;
                end
                FILTER: begin
                    gain.r_gain     <= (first_done && IIR_SHIFT != 0) ? smooth(gain.r_gain, r_clamp) : r_clamp;
                    gain.b_gain     <= (first_done && IIR_SHIFT != 0) ? smooth(gain.b_gain, b_clamp) : b_clamp;
                    first_done      <= 1'b1;
                    gain.gain_valid <= 1'b1;
                    state           <= PRESENT;
                end
                PRESENT: if (gain.gain_ready) begin
                    gain.gain_valid <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_als_wb_gain.sv
// tb_als_wb_gain: table-driven scoreboard bench for als_wb_gain; runs an
// unsmoothed instance and an IIR_SHIFT=2 instance on the same stimulus.
module tb_als_wb_gain;
    import als_pkg::*;

    typedef struct {
        logic [9:0] c0, c1, c2, c3;
        int         r, b;
    } vec_t;

    typedef struct {
        int r0, b0, r2, b2;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b1;
    logic       avg_valid = 1'b0;
    logic       ready = 1'b0;
    logic [9:0] ch0 = '0, ch1 = '0, ch2 = '0, ch3 = '0;
    logic       busy0, busy2;
    logic [15:0] drops0, drops2;

    int   checks = 0;
    int   errors = 0;
    int   exp_drops = 0;
    exp_t sb[$];
    bit   m_first = 1'b0;
    int   m_r2 = GAIN_ONE, m_b2 = GAIN_ONE;
    vec_t vecs[10];

    als_wb_gain_if #(.GAIN_BITS(12)) g0 ();
    als_wb_gain_if #(.GAIN_BITS(12)) g2 ();
    assign g0.gain_ready = ready;
    assign g2.gain_ready = ready;

    always #5 clk = ~clk;

    als_wb_gain u0 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .avg_valid(avg_valid),
        .ch0_avg(ch0), .ch1_avg(ch1), .ch2_avg(ch2), .ch3_avg(ch3),
        .busy(busy0), .drop_count(drops0), .gain(g0)
    );

    als_wb_gain #(.IIR_SHIFT(2)) u2 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .avg_valid(avg_valid),
        .ch0_avg(ch0), .ch1_avg(ch1), .ch2_avg(ch2), .ch3_avg(ch3),
        .busy(busy2), .drop_count(drops2), .gain(g2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected smoothed pair: first frame after reset passes through, later ones move a quarter of the way.
    task automatic push(input int r, input int b);
        exp_t e;
        e.r0 = r;
        e.b0 = b;
        e.r2 = m_first ? m_r2 + ((r - m_r2) >>> 2) : r;
        e.b2 = m_first ? m_b2 + ((b - m_b2) >>> 2) : b;
        m_first = 1'b1;
        m_r2 = e.r2;
        m_b2 = e.b2;
        sb.push_back(e);
    endtask

    task automatic send(input logic [9:0] a0, a1, a2, a3, input int r, b, input bit accept);
        @(negedge clk);
        ch0 = a0; ch1 = a1; ch2 = a2; ch3 = a3;
        avg_valid = 1'b1;
        if (accept) push(r, b);
        @(negedge clk);
        avg_valid = 1'b0;
    endtask

    task automatic drop_pulse();
        avg_valid = 1'b1;
        @(negedge clk);
        avg_valid = 1'b0;
        exp_drops++;
    endtask

    // k = cycles already elapsed since the accepting edge.
    task automatic wait_check(input int k0, output exp_t e);
        int k;
        k = k0;
        while (!g0.gain_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("latency", k, 38);
        chk("sb_size", sb.size(), 1);
        e = '{0, 0, 0, 0};
        if (sb.size() != 0) e = sb.pop_front();
        chk("r_gain", g0.r_gain, e.r0);
        chk("b_gain", g0.b_gain, e.b0);
        chk("iir_valid", g2.gain_valid, 1);
        chk("iir_r_gain", g2.r_gain, e.r2);
        chk("iir_b_gain", g2.b_gain, e.b2);
    endtask

    task automatic collect(input bit quick);
        exp_t e;
        wait_check(0, e);
        if (quick) begin
            @(negedge clk);
            chk("valid_one_cycle", g0.gain_valid, 0);
            chk("busy_after_xfer", busy0, 0);
        end else begin
            repeat (3) @(negedge clk);
            chk("hold_r", g0.r_gain, e.r0);
            chk("hold_valid", g0.gain_valid, 1);
            ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
            chk("valid_after_ready", g0.gain_valid, 0);
            chk("busy_after_ready", busy0, 0);
            chk("iir_busy_after_ready", busy2, 0);
        end
    endtask

    initial begin
        exp_t e;
        vecs[0] = '{10'd200, 10'd100, 10'd200, 10'd200, 512, 256};
        vecs[1] = '{10'd200, 10'd200, 10'd200, 10'd200, 256, 256};
        vecs[2] = '{10'd200, 10'd100, 10'd300, 10'd200, 512, 170};
        vecs[3] = '{10'd200, 10'd0,   10'd300, 10'd200, 1024, 170};
        vecs[4] = '{10'd200, 10'd10,  10'd200, 10'd200, 1024, 256};
        vecs[5] = '{10'd0,   10'd100, 10'd50,  10'd0,   32, 32};
        vecs[6] = '{10'd201, 10'd67,  10'd1023, 10'd200, 768, 50};
        vecs[7] = '{10'd1023, 10'd1023, 10'd1, 10'd1023, 256, 1024};
        vecs[8] = '{10'd100, 10'd255, 10'd13,  10'd101, 101, 1024};
        vecs[9] = '{10'd50,  10'd800, 10'd0,   10'd50,  32, 1024};

        repeat (2) @(negedge clk);
        chk("rst_r_gain", g0.r_gain, GAIN_ONE);
        chk("rst_b_gain", g0.b_gain, GAIN_ONE);
        chk("rst_valid", g0.gain_valid, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_drops", drops0, 0);
        chk("rst_iir_r_gain", g2.r_gain, GAIN_ONE);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            ready = i[0];
            send(vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].c3, vecs[i].r, vecs[i].b, 1'b1);
            collect(i[0]);
        end

        ready = 1'b0;
        send(10'd200, 10'd100, 10'd300, 10'd200, 512, 170, 1'b1);
        repeat (5) @(negedge clk);
        drop_pulse();
        repeat (5) @(negedge clk);
        drop_pulse();
        wait_check(12, e);
        drop_pulse();
        chk("drops_three", drops0, exp_drops);
        chk("iir_drops_three", drops2, exp_drops);
        chk("bp_hold_r", g0.r_gain, 512);
        chk("bp_hold_b", g0.b_gain, 170);
        chk("bp_hold_valid", g0.gain_valid, 1);
        chk("bp_busy", busy0, 1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("bp_busy_released", busy0, 0);

        enable = 1'b0;
        send(10'd200, 10'd100, 10'd300, 10'd200, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        chk("disabled_busy", busy0, 0);
        chk("disabled_drops", drops0, exp_drops);
        enable = 1'b1;

        ready = 1'b1;
        send(10'd0, 10'd100, 10'd50, 10'd0, 32, 32, 1'b1);
        enable = 1'b0;
        collect(1'b1);
        enable = 1'b1;
        chk("midframe_disable_drops", drops0, exp_drops);

        ready = 1'b0;
        send(10'd200, 10'd100, 10'd300, 10'd200, 512, 170, 1'b1);
        repeat (25) @(negedge clk);
        chk("div_b_busy", busy0, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_r_gain", g0.r_gain, GAIN_ONE);
        chk("mid_rst_b_gain", g0.b_gain, GAIN_ONE);
        chk("mid_rst_valid", g0.gain_valid, 0);
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_drops", drops0, 0);
        sb.delete();
        m_first = 1'b0;
        m_r2 = GAIN_ONE;
        m_b2 = GAIN_ONE;
        exp_drops = 0;
        @(negedge clk);
        reset_n = 1'b1;
        send(10'd200, 10'd10, 10'd200, 10'd200, 1024, 256, 1'b1);
        collect(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
